square_wave_calc: RTL and testbench

//   Converts raw timestamp counts from the square-wave measurement stage into engineering values:

---
 rtl/square_wave_calc_if.sv | 24 ++
 rtl/square_wave_calc.sv | 151 +++++++++++++++
 tb/tb_square_wave_calc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/square_wave_calc_if.sv
// Measurement-in / result-out bundle for the square-wave calculator.
// The master drives a measurement word and observes the results; the slave is the calculator.
interface square_wave_calc_if;
    logic        meas_valid;
    logic        meas_ready;
    logic [15:0] meas_cycles;
    logic [31:0] meas_period;
    logic [31:0] meas_high;
    logic        res_valid;
    logic [31:0] res_freq;
    logic [9:0]  res_duty;
    logic        res_err;
    logic        busy;

    modport master (
        output meas_valid, meas_cycles, meas_period, meas_high,
        input  meas_ready, res_valid, res_freq, res_duty, res_err, busy
    );

    modport slave (
        input  meas_valid, meas_cycles, meas_period, meas_high,
        output meas_ready, res_valid, res_freq, res_duty, res_err, busy
    );
endinterface

// File: rtl/square_wave_calc.sv
// Square-wave calculator: turns period/high-time tick counts into frequency (Hz) and
// duty cycle (permille) using one shared serial restoring divider, one quotient bit per clock.
// The frequency divide runs first, then the same divider is reloaded for the duty divide.
module square_wave_calc #(
    parameter int unsigned PLL_FREQ   = 200_000_000,
    parameter int unsigned DUTY_SCALE = 1000,
    parameter int unsigned DIV_W      = 48
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    square_wave_calc_if.slave bus
);

    localparam int unsigned ITER_W = $clog2(DIV_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DIV_F,
        DIV_D,
        DONE
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic [15:0]         r_cycles;
    logic [31:0]         r_period;
    logic [31:0]         r_high;
    logic [DIV_W-1:0]    r_quo;
    logic [31:0]         r_rem;
    logic [ITER_W-1:0]   r_iter;
    logic [31:0]         r_freqQ;
    logic                r_resValid;
    logic [31:0]         r_resFreq;
    logic [9:0]          r_resDuty;
    logic                r_resErr;

    logic [32:0]         w_trial;
    logic                w_ge;
    logic [31:0]         w_remNext;
    logic [DIV_W-1:0]    w_quoNext;
    logic [31:0]         w_freqSat;
    logic                w_badInput;

    // One restoring-division step: shift the next dividend bit into the remainder and subtract if it fits
    always_comb begin
        w_trial    = {r_rem, r_quo[DIV_W-1]};
        w_ge       = (w_trial >= {1'b0, r_period});
        w_remNext  = w_ge ? 32'(w_trial - {1'b0, r_period}) : w_trial[31:0];
        w_quoNext  = {r_quo[DIV_W-2:0], w_ge};
        w_freqSat  = (|w_quoNext[DIV_W-1:32]) ? 32'hFFFF_FFFF : w_quoNext[31:0];
        w_badInput = (r_period == 32'd0) || (r_cycles == 16'd0) || (r_high > r_period);
    end

    // Control FSM, shared divider datapath and registered result outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_cycles   <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_iter     <= '0;
            r_freqQ    <= '0;
            r_resValid <= 1'b0;
            r_resFreq  <= '0;
            r_resDuty  <= '0;
            r_resErr   <= 1'b0;
        end else begin
            r_resValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.meas_valid && r_ready) begin
                        r_cycles <= bus.meas_cycles;
                        r_period <= bus.meas_period;
                        r_high   <= bus.meas_high;
                        r_ready  <= 1'b0;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_quo   <= DIV_W'(r_cycles) * DIV_W'(PLL_FREQ);
                    r_rem   <= '0;
                    r_iter  <= '0;
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_badInput) begin
                        r_resFreq  <= '0;
                        r_resDuty  <= '0;
                        r_resErr   <= 1'b1;
                        r_resValid <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_state <= DIV_F;
                    end
                end
                DIV_F: begin
                    r_quo <= w_quoNext;
                    r_rem <= w_remNext;
                    if (r_iter == ITER_W'(DIV_W - 1)) begin
                        r_freqQ <= w_freqSat;
                        r_iter  <= '0;
                        r_state <= DIV_D;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                DIV_D: begin
                    // First cycle reloads the shared divider with the duty dividend
                    if (r_iter == '0) begin
                        r_quo  <= DIV_W'(r_high) * DIV_W'(DUTY_SCALE);
                        r_rem  <= '0;
                        r_iter <= ITER_W'(1);
                    end else begin
                        r_quo <= w_quoNext;
                        r_rem <= w_remNext;
                        if (r_iter == ITER_W'(DIV_W)) begin
                            r_resFreq  <= r_freqQ;
                            r_resDuty  <= w_quoNext[9:0];
                            r_resErr   <= 1'b0;
                            r_resValid <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_iter <= r_iter + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.meas_ready = r_ready;
    assign bus.busy       = ~r_ready;
    assign bus.res_valid  = r_resValid;
    assign bus.res_freq   = r_resFreq;
    assign bus.res_duty   = r_resDuty;
    assign bus.res_err    = r_resErr;

endmodule

// File: tb/tb_square_wave_calc.sv
// Testbench for square_wave_calc: directed cases, randomized measurements against an
// arithmetic reference model, handshake/latency checks and reset-during-divide behaviour.
module tb_square_wave_calc;

    logic sysClk = 1'b0;
    logic sysRst = 1'b1;
    int   nCompared    = 0;
    int   nMismatched  = 0;
    int   cycleCnt     = 0;
    int   doublePulses = 0;
    logic prevValid    = 1'b0;

    square_wave_calc_if bus ();

    square_wave_calc dut (
        .sys_clk (sysClk),
        .sys_rst (sysRst),
        .bus     (bus)
    );

    // Free-running clock
    always #5 sysClk = ~sysClk;

    // Cycle counter used to measure result latency
    always @(posedge sysClk) cycleCnt <= cycleCnt + 1;

    // Watch for res_valid held high on two consecutive cycles
    always @(negedge sysClk) begin
        if (bus.res_valid && prevValid) doublePulses++;
        prevValid = bus.res_valid;
    end

    // Reference: frequency and duty straight from the arithmetic definition
    function automatic void refModel(input logic [15:0] cyc, input logic [31:0] per,
                                     input logic [31:0] hi, output logic [31:0] f,
                                     output logic [31:0] d, output logic e);
        longint unsigned num;
        if (per == 32'd0 || cyc == 16'd0 || hi > per) begin
            f = 32'd0;
            d = 32'd0;
            e = 1'b1;
        end else begin
            num = (64'(cyc) * 64'd200_000_000) / 64'(per);
            f   = (num > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : num[31:0];
            d   = 32'((64'(hi) * 64'd1000) / 64'(per));
            e   = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one measurement, wait (bounded) for its result and check values, latency and handshake
    task automatic applyStimulus(input logic [15:0] cyc, input logic [31:0] per, input logic [31:0] hi);
        logic [31:0] expFreq;
        logic [31:0] expDuty;
        logic        expErr;
        int          expLat;
        int          tAcc;
        int          lat;
        bit          seen;
        refModel(cyc, per, hi, expFreq, expDuty, expErr);
        expLat = expErr ? 3 : 100;
        @(posedge sysClk); #1;
        checkOutput("readyBeforeAccept", 32'(bus.meas_ready), 32'd1);
        bus.meas_valid  = 1'b1;
        bus.meas_cycles = cyc;
        bus.meas_period = per;
        bus.meas_high   = hi;
        @(posedge sysClk); #1;
        tAcc            = cycleCnt;
        bus.meas_valid  = 1'b0;
        bus.meas_cycles = 16'($urandom());
        bus.meas_period = $urandom();
        bus.meas_high   = $urandom();
        checkOutput("readyAfterAccept", 32'(bus.meas_ready), 32'd0);
        checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (i == 10) bus.meas_valid = 1'b1;
            if (i == 13) bus.meas_valid = 1'b0;
            @(posedge sysClk); #1;
            if (bus.res_valid) begin
                seen = 1'b1;
                lat  = cycleCnt - tAcc + 1;
            end
        end
        bus.meas_valid = 1'b0;
        checkOutput("pulseSeen", 32'(seen), 32'd1);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("resFreq", bus.res_freq, expFreq);
        checkOutput("resDuty", 32'(bus.res_duty), expDuty);
        checkOutput("resErr", 32'(bus.res_err), 32'(expErr));
        checkOutput("readyAtPulse", 32'(bus.meas_ready), 32'd0);
        @(posedge sysClk); #1;
        checkOutput("pulseOneCycle", 32'(bus.res_valid), 32'd0);
        checkOutput("readyAfterPulse", 32'(bus.meas_ready), 32'd1);
        checkOutput("busyAfterPulse", 32'(bus.busy), 32'd0);
        checkOutput("freqHeld", bus.res_freq, expFreq);
        checkOutput("dutyHeld", 32'(bus.res_duty), expDuty);
    endtask

    initial begin
        int          tAcc;
        int          pulses;
        int          mode;
        logic [15:0] rCyc;
        logic [31:0] rPer;
        logic [31:0] rHi;

        $display("[TB] start");
        bus.meas_valid  = 1'b1;
        bus.meas_cycles = 16'd1;
        bus.meas_period = 32'd200;
        bus.meas_high   = 32'd100;

        // Reset held with a valid word present: it must be ignored
        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("rstValid", 32'(bus.res_valid), 32'd0);
        checkOutput("rstFreq", bus.res_freq, 32'd0);
        checkOutput("rstDuty", 32'(bus.res_duty), 32'd0);
        checkOutput("rstErr", 32'(bus.res_err), 32'd0);
        checkOutput("rstReady", 32'(bus.meas_ready), 32'd1);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        bus.meas_valid = 1'b0;
        sysRst         = 1'b0;
        @(posedge sysClk); #1;
        checkOutput("readyAfterRelease", 32'(bus.meas_ready), 32'd1);

        // Directed cases
        applyStimulus(16'd1, 32'd200, 32'd100);
        applyStimulus(16'd1000, 32'd200_000_000, 32'd50_000_000);
        applyStimulus(16'd1, 32'd7, 32'd7);
        applyStimulus(16'd65535, 32'd1, 32'd0);
        applyStimulus(16'd5, 32'd0, 32'd0);
        applyStimulus(16'd1, 32'd200, 32'd300);
        applyStimulus(16'd0, 32'd200, 32'd100);
        applyStimulus(16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Randomized measurements
        for (int n = 0; n < 20; n++) begin
            mode = int'($urandom_range(3, 0));
            rCyc = 16'($urandom_range(65535, 1));
            case (mode)
                0: begin
                    rPer = $urandom_range(1000, 1);
                    rHi  = $urandom_range(rPer, 0);
                end
                1: begin
                    rPer = $urandom();
                    rHi  = $urandom_range(rPer, 0);
                end
                2: begin
                    rPer = $urandom_range(1_000_000, 1);
                    rHi  = rPer + $urandom_range(100, 1);
                end
                default: begin
                    rCyc = 16'($urandom_range(3, 0));
                    rPer = $urandom_range(100_000, 0);
                    rHi  = $urandom_range(rPer, 0);
                end
            endcase
            applyStimulus(rCyc, rPer, rHi);
        end

        // Reset in the middle of a divide: no pulse, outputs back to reset values
        applyStimulus(16'd1, 32'd200, 32'd100);
        @(posedge sysClk); #1;
        bus.meas_valid  = 1'b1;
        bus.meas_cycles = 16'd1;
        bus.meas_period = 32'd200;
        bus.meas_high   = 32'd100;
        @(posedge sysClk); #1;
        tAcc           = cycleCnt;
        bus.meas_valid = 1'b0;
        pulses         = 0;
        repeat (49) begin
            if (bus.res_valid) pulses++;
            @(posedge sysClk); #1;
        end
        checkOutput("reachedT50", 32'(cycleCnt - tAcc + 1), 32'd50);
        sysRst = 1'b1;
        @(posedge sysClk); #1;
        sysRst = 1'b0;
        checkOutput("midRstFreq", bus.res_freq, 32'd0);
        checkOutput("midRstDuty", 32'(bus.res_duty), 32'd0);
        checkOutput("midRstErr", 32'(bus.res_err), 32'd0);
        checkOutput("midRstValid", 32'(bus.res_valid), 32'd0);
        checkOutput("midRstReady", 32'(bus.meas_ready), 32'd1);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        repeat (120) begin
            @(posedge sysClk); #1;
            if (bus.res_valid) pulses++;
        end
        checkOutput("noPulseAfterRst", 32'(pulses), 32'd0);
        applyStimulus(16'd1, 32'd200, 32'd100);

        checkOutput("noDoublePulse", 32'(doublePulses), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
